alu_muldiv: RTL and testbench

Multi-cycle execute unit, parametrised successor to the single-cycle ALU. Executes all base integer ops plus the RV32M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). Uses a valid/ready handshake on input and output so the datapath can stall during iterative operations. Sits in the EX stage. Control asserts in_valid with operands, and the hazard unit stalls the pipeline while in_ready is low.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_base_comb.sv | 42 ++++
 rtl/alu_muldiv.sv | 200 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU / multiply-divide execute unit.
package alu_pkg;

    localparam int unsigned ALU_OPCODE_LENGTH = 5;

    // Operation codes; bit 4 selects the multiply/divide group.
    typedef enum logic [ALU_OPCODE_LENGTH-1:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SLTU   = 5'b00110,
        OP_SGEU   = 5'b00111,
        OP_EQ     = 5'b01000,
        OP_NE     = 5'b01001,
        OP_SUB    = 5'b01010,
        OP_ADD    = 5'b01011,
        OP_SLT    = 5'b01100,
        OP_SRA    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // True for the eight iterative multiply/divide codes (10xxx); 11xxx is undefined.
    function automatic logic is_mdu_op(input logic [ALU_OPCODE_LENGTH-1:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Purely combinational evaluator for the single-cycle base integer ops.
module alu_base_comb
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [3:0]            op_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt_s;
    alu_op_e        op_s;

    assign shamt_s = b_i[SHW-1:0];
    assign op_s    = alu_op_e'({1'b0, op_i});

    // Decode the base opcode; compares produce a zero-extended 1/0, unknown codes give 0.
    always_comb begin
        result_o = {DATA_WIDTH{1'b0}};
        case (op_s)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt_s;
            OP_SRL:  result_o = a_i >> shamt_s;
            OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt_s);
            OP_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i <  b_i)};
            OP_SGEU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i >= b_i)};
            OP_EQ:   result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
            OP_NE:   result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i != b_i)};
            OP_SUB:  result_o = a_i - b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle EX-stage unit: single-cycle base ops plus iterative RV32M mul/div
// behind valid/ready handshakes. Mul and div share the accumulator/shift registers.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    alu_state_e       state_q;
    logic [4:0]       op_q;
    logic [DW-1:0]    acc_q;      // product high half / partial remainder
    logic [DW-1:0]    low_q;      // multiplier being shifted out / quotient being shifted in
    logic [DW-1:0]    opb_q;      // multiplicand or divisor magnitude
    logic [DW-1:0]    a_raw_q;    // untouched SrcA for the divide corner results
    logic             sign_a_q;
    logic             sign_b_q;
    logic             div_zero_q;
    logic             div_ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    result_q;
    logic             in_ready_q;
    logic             out_valid_q;

    alu_op_e          op_in_s;
    logic             a_sgn_s, b_sgn_s;
    logic             neg_a_s, neg_b_s;
    logic [DW-1:0]    mag_a_s, mag_b_s;
    logic             div_zero_s, div_ovf_s;
    logic [DW-1:0]    base_result_s;

    logic [DW:0]      add_s;
    logic [DW:0]      shl_s;
    logic [DW-1:0]    sub_s;
    logic             ge_s;
    logic [DW-1:0]    step_acc_d, step_low_d;
    logic [2*DW-1:0]  prod_s;
    logic [DW-1:0]    quo_s, rem_s;
    logic [DW-1:0]    mdu_result_d;

    assign op_in_s   = alu_op_e'(Operation[4:0]);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;

    alu_base_comb #(.DATA_WIDTH(DW)) u_base (
        .a_i      (SrcA),
        .b_i      (SrcB),
        .op_i     (Operation[3:0]),
        .result_o (base_result_s)
    );

    // Operand signedness per op, magnitudes and divide corner detection at accept.
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (op_in_s)
            OP_MULH:        begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            OP_MULHSU:      begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
            OP_DIV, OP_REM: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            default:        begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
        endcase
        neg_a_s    = a_sgn_s & SrcA[DW-1];
        neg_b_s    = b_sgn_s & SrcB[DW-1];
        mag_a_s    = neg_a_s ? -SrcA : SrcA;
        mag_b_s    = neg_b_s ? -SrcB : SrcB;
        div_zero_s = (SrcB == {DW{1'b0}});
        div_ovf_s  = Operation[2] & b_sgn_s & (SrcA == MOST_NEG) & (SrcB == {DW{1'b1}});
    end

    // One shift-add (multiply) or restoring-subtract (divide) step on the shared registers.
    always_comb begin
        add_s = {1'b0, acc_q} + {1'b0, (low_q[0] ? opb_q : {DW{1'b0}})};
        shl_s = {acc_q, low_q[DW-1]};
        ge_s  = (shl_s >= {1'b0, opb_q});
        sub_s = shl_s[DW-1:0] - opb_q;
        if (op_q[2]) begin
            step_acc_d = ge_s ? sub_s : shl_s[DW-1:0];
            step_low_d = {low_q[DW-2:0], ge_s};
        end else begin
            step_acc_d = add_s[DW:1];
            step_low_d = {add_s[0], low_q[DW-1:1]};
        end
    end

    // Sign correction and corner overrides applied to the last step's values.
    always_comb begin
        prod_s = {step_acc_d, step_low_d};
        if (sign_a_q ^ sign_b_q) begin
            prod_s = -prod_s;
        end else begin
            prod_s = {step_acc_d, step_low_d};
        end
        quo_s = (sign_a_q ^ sign_b_q) ? -step_low_d : step_low_d;
        rem_s = sign_a_q ? -step_acc_d : step_acc_d;
        if (div_zero_q) begin
            quo_s = {DW{1'b1}};
            rem_s = a_raw_q;
        end else if (div_ovf_q) begin
            quo_s = a_raw_q;
            rem_s = {DW{1'b0}};
        end else begin
            quo_s = quo_s;
            rem_s = rem_s;
        end
        case (op_q[2:0])
            3'b000:                 mdu_result_d = prod_s[DW-1:0];
            3'b001, 3'b010, 3'b011: mdu_result_d = prod_s[2*DW-1:DW];
            3'b100, 3'b101:         mdu_result_d = quo_s;
            3'b110, 3'b111:         mdu_result_d = rem_s;
            default:                mdu_result_d = {DW{1'b0}};
        endcase
    end

    // Control FSM and datapath registers: IDLE accepts, CALC iterates, DONE holds the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 5'b00000;
            acc_q       <= {DW{1'b0}};
            low_q       <= {DW{1'b0}};
            opb_q       <= {DW{1'b0}};
            a_raw_q     <= {DW{1'b0}};
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            div_ovf_q   <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            result_q    <= {DW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= Operation[4:0];
                        a_raw_q    <= SrcA;
                        in_ready_q <= 1'b0;
                        if (is_mdu_op(Operation[4:0])) begin
                            acc_q      <= {DW{1'b0}};
                            // Multiply shifts B out of low_q; divide shifts A's bits through it.
                            low_q      <= Operation[2] ? mag_a_s : mag_b_s;
                            opb_q      <= Operation[2] ? mag_b_s : mag_a_s;
                            sign_a_q   <= neg_a_s;
                            sign_b_q   <= neg_b_s;
                            div_zero_q <= Operation[2] & div_zero_s;
                            div_ovf_q  <= div_ovf_s;
                            cnt_q      <= CNT_LOAD;
                            state_q    <= ST_CALC;
                        end else begin
                            result_q    <= Operation[4] ? {DW{1'b0}} : base_result_s;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= step_acc_d;
                    low_q <= step_low_d;
                    cnt_q <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= mdu_result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (DATA_WIDTH=32).
module tb_alu_muldiv;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  Operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;

    int n_assert;
    int n_fail;

    alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op, count edges (accept edge included) until out_valid, then handshake.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        SrcA = a; SrcB = b; Operation = op; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0;
        chk({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, ALUResult, exp);
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = 32'd0; SrcB = 32'd0; Operation = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", ALUResult, 32'd0);
        reset = 1'b0;

        // Base ops
        do_op("add", 5'b01011, 32'd5, 32'd7, 32'd12, 1);
        do_op("xor", 5'b00011, 32'hF0F0_1234, 32'h0FF0_0004, 32'hFF00_1230, 1);
        do_op("slt", 5'b01100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        do_op("sltu", 5'b00110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        do_op("sll_mask", 5'b00100, 32'd1, 32'd33, 32'd2, 1);
        do_op("undef_m", 5'b11000, 32'd9, 32'd9, 32'd0, 1);

        // Multiply group
        do_op("mul", 5'b10000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
        do_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33);
        do_op("mulh", 5'b10001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("mul_small", 5'b10000, 32'd1234, 32'd5678, 32'd7006652, 33);

        // Divide group
        do_op("div", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("divu", 5'b10101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        do_op("remu", 5'b10111, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
        do_op("divu_by0", 5'b10101, 32'd10, 32'd0, 32'hFFFF_FFFF, 33);
        do_op("remu_by0", 5'b10111, 32'd10, 32'd0, 32'd10, 33);
        do_op("rem_by0", 5'b10110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
        do_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        do_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Backpressure: SUB result held while ADD waits on in_valid
        SrcA = 32'd3; SrcB = 32'd5; Operation = 5'b01010; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        SrcA = 32'd20; SrcB = 32'd22; Operation = 5'b01011;
        chk("bp_sub_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_sub_result", ALUResult, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", ALUResult, 32'hFFFF_FFFE);
            chk("bp_hold_flags", {30'd0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        chk("bp_release_result", ALUResult, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_add_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_add_result", ALUResult, 32'd42);
        @(posedge clk); #1;
        chk("bp_add_done", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in the middle of a multiply
        SrcA = 32'd77; SrcB = 32'd3; Operation = 5'b10000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midop_busy", {30'd0, in_ready, out_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midop_rst_flags", {30'd0, in_ready, out_valid}, 32'd2);
        chk("midop_rst_result", ALUResult, 32'd0);
        // 37 & 31 = 5: arithmetic shift of 0x80000000 by 5
        do_op("sra_after_rst", 5'b01101, 32'h8000_0000, 32'd37, 32'hFC00_0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
